csi2tx_p2b_ctrl: RTL and testbench

//  Sequencer for the pixel-to-byte converter bank (RAW6/7/8/10/12/14). Latches the line data type
//  at start-of-line, drives the one-hot converter enable, group pixel counter, data-valid and
//  end-of-line edge pulse, and checks the line byte count against the programmed word count.

---
 rtl/csi2tx_p2b_ctrl_pkg.sv | 28 ++
 rtl/csi2tx_p2b_dt_decode.sv | 23 ++
 rtl/csi2tx_p2b_ctrl.sv | 136 +++++++++++++
 tb/tb_csi2tx_p2b_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2tx_p2b_ctrl_pkg.sv
// Shared types for the CSI-2 pixel-to-byte sequencer:
// data type codes, FSM states and decoded DT info.
package csi2tx_p2b_ctrl_pkg;

  localparam logic [5:0] DT_RAW6  = 6'h28;
  localparam logic [5:0] DT_RAW7  = 6'h29;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;
  localparam logic [5:0] DT_RAW14 = 6'h2D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOL,
    S_ACTIVE,
    S_EOL,
    S_DROP
  } state_t;

  // en is one-hot {raw14,raw12,raw10,raw8,raw7,raw6}
  typedef struct packed {
    logic       ok;
    logic [5:0] en;
    logic [3:0] bpp;
    logic [4:0] gm1;
  } dt_info_t;

endpackage

// File: rtl/csi2tx_p2b_dt_decode.sv
// Combinational DT decode: support flag, converter
// one-hot, bits per pixel and packing group size - 1.
module csi2tx_p2b_dt_decode
  import csi2tx_p2b_ctrl_pkg::*;
(
  input  logic [5:0] dt,
  output dt_info_t   info
);

  always_comb begin
    info = '0;
    unique case (1'b1)
      (dt == DT_RAW6):  info = '{1'b1, 6'b000001, 4'd6,  5'd15};
      (dt == DT_RAW7):  info = '{1'b1, 6'b000010, 4'd7,  5'd31};
      (dt == DT_RAW8):  info = '{1'b1, 6'b000100, 4'd8,  5'd3};
      (dt == DT_RAW10): info = '{1'b1, 6'b001000, 4'd10, 5'd15};
      (dt == DT_RAW12): info = '{1'b1, 6'b010000, 4'd12, 5'd7};
      (dt == DT_RAW14): info = '{1'b1, 6'b100000, 4'd14, 5'd15};
      default:          info = '0;
    endcase
  end

endmodule

// File: rtl/csi2tx_p2b_ctrl.sv
// Pixel-to-byte sequencer: line framing, converter enable,
// group pixel counter, bit accumulator and word count check.
module csi2tx_p2b_ctrl
  import csi2tx_p2b_ctrl_pkg::*;
#(
  parameter int WC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_en,
  input  logic [5:0]      cfg_dt,
  input  logic [WC_W-1:0] cfg_wc,
  input  logic            sensor_pixel_vld,
  output logic [4:0]      pixel_cnt,
  output logic            pixel_data_vld,
  output logic            sensor_pixel_vld_falling_edge,
  output logic [5:0]      convrn_en,
  output logic [WC_W-1:0] line_byte_cnt,
  output logic            line_done,
  output logic            wc_err,
  output logic            dt_err,
  output logic            busy
);

  localparam int AW = WC_W + 3;

  state_t          state;
  dt_info_t        info;
  logic            vld_d;
  logic [AW-1:0]   acc;
  logic [3:0]      bpp_lat;
  logic [4:0]      gm1_lat;
  logic [5:0]      en_q;
  logic [WC_W-1:0] wc_lat;

  logic            sol;
  logic            eol;
  logic            sol_go;
  logic            accept;
  logic            reject;
  logic [AW:0]     acc_sum;
  logic [AW-1:0]   acc_nxt;
  logic [WC_W:0]   byte_full;
  logic            ovf;
  logic [WC_W-1:0] byte_nxt;
  logic [4:0]      cnt_nxt;

  csi2tx_p2b_dt_decode u_dec (
    .dt   (cfg_dt),
    .info (info)
  );

  assign sol    = sensor_pixel_vld & ~vld_d;
  assign eol    = vld_d & ~sensor_pixel_vld;
  assign sol_go = sol & cfg_en &
                  ((state == S_WAIT_SOL) | (state == S_EOL));
  assign accept = sol_go & info.ok;
  assign reject = sol_go & ~info.ok;

  // Accumulator saturates; all-ones marks an overflowed line
  assign acc_sum   = {1'b0, acc} + (AW+1)'(bpp_lat);
  assign acc_nxt   = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
  assign byte_full = {1'b0, acc[AW-1:3]} + (WC_W+1)'(|acc[2:0]);
  assign ovf       = (&acc) | byte_full[WC_W];
  assign byte_nxt  = ovf ? '1 : byte_full[WC_W-1:0];
  assign cnt_nxt   = (pixel_cnt == gm1_lat) ? 5'd0 : pixel_cnt + 5'd1;

  assign pixel_data_vld = accept |
                          ((state == S_ACTIVE) & sensor_pixel_vld);
  assign sensor_pixel_vld_falling_edge = (state == S_ACTIVE) & eol;
  assign convrn_en = accept ? info.en : en_q;
  assign busy = (state == S_ACTIVE) | (state == S_EOL) |
                (state == S_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      vld_d         <= 1'b1;
      acc           <= '0;
      pixel_cnt     <= '0;
      bpp_lat       <= '0;
      gm1_lat       <= '0;
      en_q          <= '0;
      wc_lat        <= '0;
      line_byte_cnt <= '0;
      line_done     <= 1'b0;
      wc_err        <= 1'b0;
      dt_err        <= 1'b0;
    end else begin
      vld_d     <= sensor_pixel_vld;
      line_done <= 1'b0;
      wc_err    <= 1'b0;
      dt_err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_en) state <= S_WAIT_SOL;
        end
        S_WAIT_SOL, S_EOL: begin
          if (accept) begin
            state     <= S_ACTIVE;
            bpp_lat   <= info.bpp;
            gm1_lat   <= info.gm1;
            en_q      <= info.en;
            wc_lat    <= cfg_wc;
            pixel_cnt <= 5'd1;
            acc       <= AW'(info.bpp);
          end else if (reject) begin
            state  <= S_DROP;
            dt_err <= 1'b1;
          end else begin
            state <= cfg_en ? S_WAIT_SOL : S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (sensor_pixel_vld) begin
            pixel_cnt <= cnt_nxt;
            acc       <= acc_nxt;
          end else begin
            state         <= S_EOL;
            line_done     <= 1'b1;
            line_byte_cnt <= byte_nxt;
            wc_err        <= ovf | (byte_nxt != wc_lat);
            pixel_cnt     <= '0;
            acc           <= '0;
            en_q          <= '0;
          end
        end
        S_DROP: begin
          if (eol) state <= cfg_en ? S_WAIT_SOL : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2tx_p2b_ctrl.sv
// Bench for csi2tx_p2b_ctrl: vector table, hand sequences
// and random lines against a line-level reference model.
module tb_csi2tx_p2b_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [5:0]  cfg_dt;
  logic [15:0] cfg_wc;
  logic        sensor_pixel_vld;
  logic [4:0]  pixel_cnt;
  logic        pixel_data_vld;
  logic        sensor_pixel_vld_falling_edge;
  logic [5:0]  convrn_en;
  logic [15:0] line_byte_cnt;
  logic        line_done;
  logic        wc_err;
  logic        dt_err;
  logic        busy;

  always #5 clk = ~clk;

  csi2tx_p2b_ctrl #(.WC_W(16)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .cfg_en                        (cfg_en),
    .cfg_dt                        (cfg_dt),
    .cfg_wc                        (cfg_wc),
    .sensor_pixel_vld              (sensor_pixel_vld),
    .pixel_cnt                     (pixel_cnt),
    .pixel_data_vld                (pixel_data_vld),
    .sensor_pixel_vld_falling_edge (sensor_pixel_vld_falling_edge),
    .convrn_en                     (convrn_en),
    .line_byte_cnt                 (line_byte_cnt),
    .line_done                     (line_done),
    .wc_err                        (wc_err),
    .dt_err                        (dt_err),
    .busy                          (busy)
  );

  typedef struct {
    logic [5:0] dt;
    int         wc;
    int         npix;
    int         gap;
    int         bytes;
    bit         wcerr;
    bit         ok;
    bit         chg;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_dterr = 0;
  int          exp_dterr = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  vec_t        vecs[12];

  always @(negedge clk) begin
    if (!rst) begin
      if (line_done) got_q.push_back({line_byte_cnt, wc_err});
      if (dt_err) n_dterr++;
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic void dt_model(input logic [5:0] dt,
                                   output bit ok, output int bpp,
                                   output int g,
                                   output logic [5:0] en);
    ok = 1'b1;
    case (dt)
      6'h28: begin bpp = 6;  g = 16; en = 6'b000001; end
      6'h29: begin bpp = 7;  g = 32; en = 6'b000010; end
      6'h2A: begin bpp = 8;  g = 4;  en = 6'b000100; end
      6'h2B: begin bpp = 10; g = 16; en = 6'b001000; end
      6'h2C: begin bpp = 12; g = 8;  en = 6'b010000; end
      6'h2D: begin bpp = 14; g = 16; en = 6'b100000; end
      default: begin ok = 1'b0; bpp = 0; g = 1; en = '0; end
    endcase
  endfunction

  task automatic run_line(input logic [5:0] dt, input int wc,
                          input int npix, input int gap,
                          input bit chg, input bit en_drop,
                          input int exp_bytes, input bit exp_wcerr,
                          input bit exp_ok);
    bit ok;
    int bpp;
    int g;
    logic [5:0] en;
    dt_model(dt, ok, bpp, g, en);
    for (int i = 0; i < npix; i++) begin
      @(posedge clk); #1;
      sensor_pixel_vld = 1'b1;
      if (i == 0) begin
        cfg_dt = dt;
        cfg_wc = wc[15:0];
      end else if (chg) begin
        cfg_dt = 6'($urandom);
        cfg_wc = 16'($urandom);
      end
      if (en_drop && i == 2) cfg_en = 1'b0;
      @(negedge clk);
      check("pix_vld", 32'(pixel_data_vld), 32'(exp_ok));
      if (exp_ok) begin
        check("pix_cnt", 32'(pixel_cnt), i % g);
        check("conv_en", 32'(convrn_en), 32'(en));
      end
    end
    @(posedge clk); #1;
    sensor_pixel_vld = 1'b0;
    @(negedge clk);
    check("eol_pulse", 32'(sensor_pixel_vld_falling_edge),
          32'(exp_ok));
    if (exp_ok) begin
      check("eol_cnt", 32'(pixel_cnt), npix % g);
      exp_q.push_back({16'(exp_bytes), exp_wcerr});
    end else begin
      exp_dterr++;
    end
    repeat (gap - 1) @(posedge clk);
  endtask

  initial begin
    vecs[0]  = '{6'h2C, 12, 8,  2, 12, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{6'h2B, 25, 20, 2, 25, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{6'h2C, 12, 5,  2, 8,  1'b1, 1'b1, 1'b0};
    vecs[3]  = '{6'h30, 0,  10, 2, 0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'h2A, 16, 16, 1, 16, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{6'h2A, 7,  7,  2, 7,  1'b0, 1'b1, 1'b1};
    vecs[6]  = '{6'h28, 1,  1,  1, 1,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{6'h29, 29, 33, 2, 29, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{6'h2D, 30, 17, 3, 30, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{6'h29, 3,  3,  1, 3,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{6'h3F, 5,  2,  1, 0,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'h2B, 5,  3,  2, 4,  1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    cfg_en = 1'b0;
    cfg_dt = '0;
    cfg_wc = '0;
    sensor_pixel_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cnt", 32'(pixel_cnt), 0);
    check("rst_byte_cnt", 32'(line_byte_cnt), 0);
    check("rst_flags", {26'd0, pixel_data_vld,
          sensor_pixel_vld_falling_edge, line_done, wc_err,
          dt_err, busy}, 0);
    check("rst_conv_en", 32'(convrn_en), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_en = 1'b1;
    repeat (3) @(posedge clk);

    foreach (vecs[k])
      run_line(vecs[k].dt, vecs[k].wc, vecs[k].npix, vecs[k].gap,
               vecs[k].chg, 1'b0, vecs[k].bytes, vecs[k].wcerr,
               vecs[k].ok);

    // reset while a line is in flight
    cfg_dt = 6'h2A;
    cfg_wc = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sensor_pixel_vld = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_vld", 32'(pixel_data_vld), 0);
      check("post_rst_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    check("post_rst_bytes", 32'(line_byte_cnt), 0);
    sensor_pixel_vld = 1'b0;
    repeat (3) @(posedge clk);
    run_line(6'h2A, 12, 12, 2, 1'b0, 1'b0, 12, 1'b0, 1'b1);

    // enable dropped mid-line: line completes, then idle
    run_line(6'h2A, 8, 8, 1, 1'b0, 1'b1, 8, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("en_off_busy", 32'(busy), 0);
    @(posedge clk); #1;
    sensor_pixel_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_off_vld", 32'(pixel_data_vld), 0);
      @(posedge clk); #1;
    end
    sensor_pixel_vld = 1'b0;
    cfg_en = 1'b1;
    repeat (3) @(posedge clk);

    // random lines against the line-level model
    for (int k = 0; k < 24; k++) begin
      bit ok;
      int bpp;
      int g;
      logic [5:0] en;
      logic [5:0] dt;
      int npix;
      int bytes;
      int wc;
      int r;
      r = $urandom_range(0, 7);
      if (r < 6) dt = 6'h28 + 6'(r);
      else begin
        dt = 6'($urandom);
        if (dt >= 6'h28 && dt <= 6'h2D) dt = 6'h30;
      end
      dt_model(dt, ok, bpp, g, en);
      npix = $urandom_range(1, 40);
      bytes = (npix * bpp + 7) / 8;
      wc = ($urandom_range(0, 1) == 1) ? bytes
                                       : $urandom_range(0, 80);
      run_line(dt, wc, npix, $urandom_range(1, 3),
               1'($urandom_range(0, 1)), 1'b0, bytes,
               bytes != wc, ok);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("line_done_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check("line_bytes", 32'(got_q[k][16:1]), 32'(exp_q[k][16:1]));
      check("line_wc_err", 32'(got_q[k][0]), 32'(exp_q[k][0]));
    end
    check("dt_err_count", n_dterr, exp_dterr);
    check("final_busy", 32'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
